// File: rtl/procyon_core_pkg.sv
// Shared core types for the fetch miss queue.
//   pcyn_ccu_len_t      : CCU burst length encoding (bytes per transfer)
//   pcyn_ifq_mq_state_t : miss-queue entry state
//   pcyn_ic_offset()    : width of the byte-offset field of an ICache line
//   pcyn_ccu_len()      : CCU length code for a given line size
package procyon_core_pkg;

  typedef enum logic [2:0] {
    PCYN_CCU_LEN_4B   = 3'd0,
    PCYN_CCU_LEN_8B   = 3'd1,
    PCYN_CCU_LEN_16B  = 3'd2,
    PCYN_CCU_LEN_32B  = 3'd3,
    PCYN_CCU_LEN_64B  = 3'd4,
    PCYN_CCU_LEN_128B = 3'd5
  } pcyn_ccu_len_t;

  typedef enum logic [1:0] {
    PCYN_IFQ_MQ_INVALID = 2'd0,
    PCYN_IFQ_MQ_PENDING = 2'd1,
    PCYN_IFQ_MQ_ISSUED  = 2'd2
  } pcyn_ifq_mq_state_t;

  function automatic int pcyn_ic_offset(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic pcyn_ccu_len_t pcyn_ccu_len(input int line_size);
    case (line_size)
      4:       return PCYN_CCU_LEN_4B;
      8:       return PCYN_CCU_LEN_8B;
      16:      return PCYN_CCU_LEN_16B;
      32:      return PCYN_CCU_LEN_32B;
      64:      return PCYN_CCU_LEN_64B;
      default: return PCYN_CCU_LEN_128B;
    endcase
  endfunction

endpackage

// File: rtl/procyon_ccu_ifq_mq_if.sv
// Fetch-side and CCU-side signals of the instruction fetch miss queue.
//   slave  : the miss queue (drives full, fill and CCU request)
//   master : the fetch unit / CCU environment
interface procyon_ccu_ifq_mq_if
  import procyon_core_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_IC_LINE_SIZE = 32
);
  localparam int DATA_W = OPTN_IC_LINE_SIZE * 8;

  logic                       o_ifq_full;
  logic                       i_ifq_alloc_en;
  logic [OPTN_ADDR_WIDTH-1:0] i_ifq_alloc_addr;
  logic                       i_ifq_flush;
  logic                       o_ifq_fill_en;
  logic [OPTN_ADDR_WIDTH-1:0] o_ifq_fill_addr;
  logic [DATA_W-1:0]          o_ifq_fill_data;
  logic                       i_ccu_done;
  logic [DATA_W-1:0]          i_ccu_data;
  logic                       o_ccu_en;
  logic                       o_ccu_we;
  pcyn_ccu_len_t              o_ccu_len;
  logic [OPTN_ADDR_WIDTH-1:0] o_ccu_addr;

  modport slave (
    output o_ifq_full, o_ifq_fill_en, o_ifq_fill_addr, o_ifq_fill_data,
    output o_ccu_en, o_ccu_we, o_ccu_len, o_ccu_addr,
    input  i_ifq_alloc_en, i_ifq_alloc_addr, i_ifq_flush, i_ccu_done, i_ccu_data
  );

  modport master (
    input  o_ifq_full, o_ifq_fill_en, o_ifq_fill_addr, o_ifq_fill_data,
    input  o_ccu_en, o_ccu_we, o_ccu_len, o_ccu_addr,
    output i_ifq_alloc_en, i_ifq_alloc_addr, i_ifq_flush, i_ccu_done, i_ccu_data
  );
endinterface

// File: rtl/procyon_ccu_ifq_mq_entry.sv
// One miss-queue entry: state, cancel bit and line address, plus two line
// comparators (demand merge and prefetch filter).
//   alloc_en/alloc_line : write a new PENDING line
//   issue               : this entry is the queue head
//   done                : head transaction completed
//   flush               : drop pending work, cancel an in-flight head
//   valid/cancelled/line/match/pf_match : status outputs
//
// state   | meaning
// INVALID | free slot
// PENDING | allocated, waiting to reach the head
// ISSUED  | head, request presented to the CCU
module procyon_ccu_ifq_mq_entry
  import procyon_core_pkg::*;
#(
  parameter int LINE_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [LINE_W-1:0] alloc_line,
  input  logic              issue,
  input  logic              done,
  input  logic              flush,
  input  logic [LINE_W-1:0] cmp_line,
  input  logic [LINE_W-1:0] pf_cmp_line,
  output logic              valid,
  output logic              cancelled,
  output logic [LINE_W-1:0] line,
  output logic              match,
  output logic              pf_match
);
  pcyn_ifq_mq_state_t state_q, state_d;
  logic               cancel_q, cancel_d;
  logic [LINE_W-1:0]  line_q, line_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PCYN_IFQ_MQ_INVALID;
      cancel_q <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      line_q   <= line_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    line_d   = line_q;
    if (flush) begin
      // A valid head is already visible to the CCU, so it must run to
      // completion; it is only marked so its fill is dropped.
      if (issue && (state_q != PCYN_IFQ_MQ_INVALID) && !done) begin
        state_d  = PCYN_IFQ_MQ_ISSUED;
        cancel_d = 1'b1;
      end else begin
        state_d  = PCYN_IFQ_MQ_INVALID;
        cancel_d = 1'b0;
      end
    end else if (done) begin
      state_d  = PCYN_IFQ_MQ_INVALID;
      cancel_d = 1'b0;
    end else if (alloc_en) begin
      state_d  = PCYN_IFQ_MQ_PENDING;
      cancel_d = 1'b0;
      line_d   = alloc_line;
    end else if (issue && (state_q == PCYN_IFQ_MQ_PENDING)) begin
      state_d = PCYN_IFQ_MQ_ISSUED;
    end
  end

  assign valid     = (state_q != PCYN_IFQ_MQ_INVALID);
  assign cancelled = cancel_q;
  assign line      = line_q;
  assign match     = valid && !cancel_q && (line_q == cmp_line);
  assign pf_match  = valid && (line_q == pf_cmp_line);
endmodule

// File: rtl/procyon_queue_ctrl.sv
// Circular queue head/tail/count bookkeeping.
//   alloc_cnt  : entries written at the tail this cycle (0, 1 or 2)
//   incr_head  : pop the head
//   flush/flush_keep : drop everything, optionally keeping the head entry
//   head/tail/count/full : registered queue state
module procyon_queue_ctrl #(
  parameter int OPTN_QUEUE_DEPTH = 4,
  localparam int PTR_W = (OPTN_QUEUE_DEPTH > 1) ? $clog2(OPTN_QUEUE_DEPTH) : 1,
  localparam int CNT_W = $clog2(OPTN_QUEUE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alloc_cnt,
  input  logic             incr_head,
  input  logic             flush,
  input  logic             flush_keep,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  // A single-entry queue never moves its pointers.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    if (OPTN_QUEUE_DEPTH == 1) return '0;
    return p + PTR_W'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // Surviving head (if any) sits alone; the tail lands right behind it.
      head_q  <= ptr_add(head_q, {1'b0, incr_head});
      tail_q  <= ptr_add(head_q, {1'b0, flush_keep | incr_head});
      count_q <= CNT_W'(flush_keep);
    end else begin
      head_q  <= ptr_add(head_q, {1'b0, incr_head});
      tail_q  <= ptr_add(tail_q, alloc_cnt);
      count_q <= count_q + CNT_W'(alloc_cnt) - CNT_W'(incr_head);
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == CNT_W'(OPTN_QUEUE_DEPTH));
endmodule

// File: rtl/procyon_ccu_ifq_mq.sv
// Instruction fetch miss queue: merges duplicate line misses, optionally adds
// a next-line prefetch, issues lines to the CCU in FIFO order and returns each
// completed line as a registered fill.
//   clk, rst : clock, synchronous active-high reset
//   ifq      : fetch alloc/flush/fill and CCU request/done signals (slave)
module procyon_ccu_ifq_mq
  import procyon_core_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_IFQ_DEPTH    = 4,
  parameter int OPTN_IC_LINE_SIZE = 32,
  parameter int OPTN_IFQ_PREFETCH = 0
) (
  input logic                 clk,
  input logic                 rst,
  procyon_ccu_ifq_mq_if.slave ifq
);
  localparam int IC_OFFSET = pcyn_ic_offset(OPTN_IC_LINE_SIZE);
  localparam int LINE_W    = OPTN_ADDR_WIDTH - IC_OFFSET;
  localparam int PTR_W     = (OPTN_IFQ_DEPTH > 1) ? $clog2(OPTN_IFQ_DEPTH) : 1;
  localparam int CNT_W     = $clog2(OPTN_IFQ_DEPTH + 1);

  logic [PTR_W-1:0]          head, tail, tail_p1;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic [LINE_W-1:0]         alloc_line, pf_line, head_line;
  logic [OPTN_IFQ_DEPTH-1:0] ent_valid, ent_cancel, ent_match, ent_pf_match;
  logic [OPTN_IFQ_DEPTH-1:0] ent_head, ent_demand, ent_pf;
  logic [LINE_W-1:0]         ent_line [OPTN_IFQ_DEPTH];
  logic                      head_valid, head_cancel, done, pf_room, demand_we, pf_we;

  assign done        = ifq.i_ccu_done;
  assign alloc_line  = ifq.i_ifq_alloc_addr[OPTN_ADDR_WIDTH-1:IC_OFFSET];
  assign pf_line     = alloc_line + LINE_W'(1);
  assign tail_p1     = (OPTN_IFQ_DEPTH == 1) ? '0 : tail + PTR_W'(1);
  assign head_valid  = ent_valid[head];
  assign head_cancel = ent_cancel[head];
  assign head_line   = ent_line[head];

  // Free-space check uses the registered count, so a same-cycle pop never
  // makes room for this cycle's allocations.
  assign pf_room   = (int'(count) + 2) <= OPTN_IFQ_DEPTH;
  assign demand_we = ifq.i_ifq_alloc_en && !ifq.i_ifq_flush && !(|ent_match) && !full;
  assign pf_we     = (OPTN_IFQ_PREFETCH != 0) && demand_we && pf_room && !(|ent_pf_match);

  procyon_queue_ctrl #(.OPTN_QUEUE_DEPTH(OPTN_IFQ_DEPTH)) u_queue_ctrl (
    .clk        (clk),
    .rst        (rst),
    .alloc_cnt  ({pf_we, demand_we && !pf_we}),
    .incr_head  (done),
    .flush      (ifq.i_ifq_flush),
    .flush_keep (head_valid && !done),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .full       (full)
  );

  for (genvar i = 0; i < OPTN_IFQ_DEPTH; i++) begin : g_entry
    assign ent_head[i]   = (head == PTR_W'(i));
    assign ent_demand[i] = demand_we && (tail == PTR_W'(i));
    assign ent_pf[i]     = pf_we && (tail_p1 == PTR_W'(i));

    procyon_ccu_ifq_mq_entry #(.LINE_W(LINE_W)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .alloc_en    (ent_demand[i] || ent_pf[i]),
      .alloc_line  (ent_demand[i] ? alloc_line : pf_line),
      .issue       (ent_head[i]),
      .done        (done && ent_head[i]),
      .flush       (ifq.i_ifq_flush),
      .cmp_line    (alloc_line),
      .pf_cmp_line (pf_line),
      .valid       (ent_valid[i]),
      .cancelled   (ent_cancel[i]),
      .line        (ent_line[i]),
      .match       (ent_match[i]),
      .pf_match    (ent_pf_match[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifq.o_ifq_fill_en   <= 1'b0;
      ifq.o_ifq_fill_addr <= '0;
      ifq.o_ifq_fill_data <= '0;
    end else begin
      ifq.o_ifq_fill_en <= done && head_valid && !head_cancel;
      if (done) begin
        ifq.o_ifq_fill_addr <= {head_line, {IC_OFFSET{1'b0}}};
        ifq.o_ifq_fill_data <= ifq.i_ccu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && done) begin
      assert (head_valid);
    end
  end

  assign ifq.o_ifq_full = full;
  assign ifq.o_ccu_en   = head_valid;
  assign ifq.o_ccu_we   = 1'b0;
  assign ifq.o_ccu_len  = pcyn_ccu_len(OPTN_IC_LINE_SIZE);
  assign ifq.o_ccu_addr = head_valid ? {head_line, {IC_OFFSET{1'b0}}} : '0;
endmodule

// File: tb/tb_procyon_ccu_ifq_mq.sv
module tb_procyon_ccu_ifq_mq;
  import procyon_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  procyon_ccu_ifq_mq_if #(.OPTN_ADDR_WIDTH(32), .OPTN_IC_LINE_SIZE(32)) fa ();
  procyon_ccu_ifq_mq_if #(.OPTN_ADDR_WIDTH(32), .OPTN_IC_LINE_SIZE(32)) fb ();

  procyon_ccu_ifq_mq #(.OPTN_ADDR_WIDTH(32), .OPTN_IFQ_DEPTH(4), .OPTN_IC_LINE_SIZE(32),
                       .OPTN_IFQ_PREFETCH(0)) dut_a (.clk(clk), .rst(rst), .ifq(fa));
  procyon_ccu_ifq_mq #(.OPTN_ADDR_WIDTH(32), .OPTN_IFQ_DEPTH(4), .OPTN_IC_LINE_SIZE(32),
                       .OPTN_IFQ_PREFETCH(1)) dut_b (.clk(clk), .rst(rst), .ifq(fb));

  int nvec = 0;
  int nerr = 0;

  // Reference model: per instance, an ordered list of queued lines with cancel flags.
  logic [26:0]  mline [2][8];
  bit           mcan  [2][8];
  int           msize [2];
  bit           efen  [2];
  logic [31:0]  efaddr[2];
  logic [255:0] efdata[2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int m, input bit al, input logic [31:0] ad, input bit fl,
                            input bit dn, input logic [255:0] d);
    int sz, pre;
    bit merged, pf_hit;
    logic [26:0] ln, nx;
    pre = msize[m];
    sz = pre;
    ln = ad[31:5];
    nx = ln + 27'd1;
    merged = 0;
    pf_hit = 0;
    for (int i = 0; i < pre; i++) begin
      if (!mcan[m][i] && mline[m][i] == ln) merged = 1;
      if (mline[m][i] == nx) pf_hit = 1;
    end
    efen[m] = 0;
    if (dn) begin
      efen[m] = !mcan[m][0];
      efaddr[m] = {mline[m][0], 5'b0};
      efdata[m] = d;
      for (int i = 0; i < 7; i++) begin
        mline[m][i] = mline[m][i+1];
        mcan[m][i] = mcan[m][i+1];
      end
      sz--;
    end
    if (fl) begin
      if (sz > 0 && !dn) begin
        sz = 1;
        mcan[m][0] = 1;
      end else sz = 0;
    end else if (al && !merged && pre < 4) begin
      mline[m][sz] = ln;
      mcan[m][sz] = 0;
      sz++;
      if (m == 1 && pre <= 2 && !pf_hit) begin
        mline[m][sz] = nx;
        mcan[m][sz] = 0;
        sz++;
      end
    end
    msize[m] = sz;
  endtask

  task automatic check_all(input int m);
    logic en, full, fen, we;
    logic [31:0] ca, fad;
    logic [255:0] fd;
    pcyn_ccu_len_t len;
    if (m == 0) begin
      en = fa.o_ccu_en; full = fa.o_ifq_full; fen = fa.o_ifq_fill_en; we = fa.o_ccu_we;
      ca = fa.o_ccu_addr; fad = fa.o_ifq_fill_addr; fd = fa.o_ifq_fill_data; len = fa.o_ccu_len;
    end else begin
      en = fb.o_ccu_en; full = fb.o_ifq_full; fen = fb.o_ifq_fill_en; we = fb.o_ccu_we;
      ca = fb.o_ccu_addr; fad = fb.o_ifq_fill_addr; fd = fb.o_ifq_fill_data; len = fb.o_ccu_len;
    end
    chk($sformatf("m%0d ccu_en", m), en, msize[m] != 0);
    if (msize[m] != 0) chk($sformatf("m%0d ccu_addr", m), ca, {mline[m][0], 5'b0});
    chk($sformatf("m%0d full", m), full, msize[m] == 4);
    chk($sformatf("m%0d fill_en", m), fen, efen[m]);
    if (efen[m]) begin
      chk($sformatf("m%0d fill_addr", m), fad, efaddr[m]);
      chk($sformatf("m%0d fill_data", m), fd, efdata[m]);
    end
    chk($sformatf("m%0d ccu_we", m), we, 1'b0);
    chk($sformatf("m%0d ccu_len", m), len, 3'd3);
  endtask

  task automatic clear_inputs();
    fa.i_ifq_alloc_en = 0; fa.i_ifq_alloc_addr = '0; fa.i_ifq_flush = 0;
    fa.i_ccu_done = 0; fa.i_ccu_data = '0;
    fb.i_ifq_alloc_en = 0; fb.i_ifq_alloc_addr = '0; fb.i_ifq_flush = 0;
    fb.i_ccu_done = 0; fb.i_ccu_data = '0;
  endtask

  task automatic step(input bit al, input logic [31:0] ad, input bit fl,
                      input bit da, input bit db, input logic [255:0] d);
    fa.i_ifq_alloc_en = al; fa.i_ifq_alloc_addr = ad; fa.i_ifq_flush = fl;
    fa.i_ccu_done = da; fa.i_ccu_data = d;
    fb.i_ifq_alloc_en = al; fb.i_ifq_alloc_addr = ad; fb.i_ifq_flush = fl;
    fb.i_ccu_done = db; fb.i_ccu_data = d;
    @(posedge clk);
    model_step(0, al, ad, fl, da, d);
    model_step(1, al, ad, fl, db, d);
    @(negedge clk);
    clear_inputs();
    check_all(0);
    check_all(1);
  endtask

  task automatic do_reset(input bit busy);
    rst = 1;
    fa.i_ifq_alloc_en = busy; fa.i_ifq_alloc_addr = 32'h0000_9000;
    fb.i_ifq_alloc_en = busy; fb.i_ifq_alloc_addr = 32'h0000_9000;
    @(posedge clk);
    msize[0] = 0; msize[1] = 0; efen[0] = 0; efen[1] = 0;
    @(negedge clk);
    clear_inputs();
    chk("rst a ccu_en", fa.o_ccu_en, 1'b0);
    chk("rst a ccu_addr", fa.o_ccu_addr, 32'h0);
    chk("rst a full", fa.o_ifq_full, 1'b0);
    chk("rst a fill_en", fa.o_ifq_fill_en, 1'b0);
    chk("rst a fill_addr", fa.o_ifq_fill_addr, 32'h0);
    chk("rst a fill_data", fa.o_ifq_fill_data, 256'h0);
    chk("rst b ccu_en", fb.o_ccu_en, 1'b0);
    chk("rst b fill_en", fb.o_ifq_fill_en, 1'b0);
    chk("rst b fill_data", fb.o_ifq_fill_data, 256'h0);
    rst = 0;
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0] ad;
    bit al, fl, da, db;
    clear_inputs();
    msize[0] = 0; msize[1] = 0;
    @(negedge clk);
    do_reset(0);

    // Single miss, issue and fill.
    step(1, 32'h0000_1004, 0, 0, 0, '0);
    chk("alloc 1004 ccu_addr", fa.o_ccu_addr, 32'h0000_1000);
    d = {8{32'hA5A5_0001}};
    step(0, '0, 0, 1, 1, d);
    chk("fill 1000 addr", fa.o_ifq_fill_addr, 32'h0000_1000);
    chk("fill 1000 data", fa.o_ifq_fill_data, d);

    // Merge of duplicate line requests.
    step(1, 32'h0000_2000, 0, 0, msize[1] != 0, '0);
    step(1, 32'h0000_2010, 0, 0, msize[1] != 0, '0);
    step(1, 32'h0000_2000, 0, 0, msize[1] != 0, '0);
    step(0, '0, 0, 1, msize[1] != 0, {8{32'h0000_2222}});
    chk("merge queue empty", fa.o_ccu_en, 1'b0);

    // Fill to full, drop a fifth, drain in order.
    for (int i = 0; i < 4; i++) step(1, 32'h0000_4000 + 32'(i) * 32, 0, 0, msize[1] != 0, '0);
    chk("four allocs full", fa.o_ifq_full, 1'b1);
    step(1, 32'h0000_4080, 0, 0, msize[1] != 0, '0);
    chk("fifth dropped full", fa.o_ifq_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 1, msize[1] != 0, {8{32'(i)}});
      chk("drain fill addr", fa.o_ifq_fill_addr, 32'h0000_4000 + 32'(i) * 32);
      if (i == 0) chk("full drops after done", fa.o_ifq_full, 1'b0);
    end

    // Flush with an in-flight head.
    step(1, 32'h0000_5000, 0, 0, msize[1] != 0, '0);
    step(1, 32'h0000_5020, 0, 0, msize[1] != 0, '0);
    step(0, '0, 1, 0, 0, '0);
    chk("flush keeps head", fa.o_ccu_addr, 32'h0000_5000);
    step(0, '0, 0, 1, msize[1] != 0, {8{32'hDEAD_BEEF}});
    chk("cancelled no fill", fa.o_ifq_fill_en, 1'b0);
    chk("flush queue empty", fa.o_ccu_en, 1'b0);

    // Prefetch instance: drain, then next-line and wraparound.
    for (int i = 0; i < 8 && msize[1] != 0; i++) step(0, '0, 0, 0, 1, '0);
    step(1, 32'h0000_3000, 0, 0, 0, '0);
    chk("pf demand addr", fb.o_ccu_addr, 32'h0000_3000);
    step(0, '0, 0, 1, 1, {8{32'h3333_0000}});
    chk("pf next addr", fb.o_ccu_addr, 32'h0000_3020);
    step(0, '0, 0, 0, 1, {8{32'h3333_0020}});
    step(1, 32'hFFFF_FFE0, 0, 0, 0, '0);
    step(0, '0, 0, 1, 1, '0);
    chk("pf wrap en", fb.o_ccu_en, 1'b1);
    chk("pf wrap addr", fb.o_ccu_addr, 32'h0);
    step(0, '0, 0, msize[0] != 0, 1, '0);

    // Reset in the middle of a transaction.
    step(1, 32'h0000_6000, 0, 0, 0, '0);
    do_reset(1);
    step(1, 32'h0000_6020, 0, 0, 0, '0);
    chk("post reset alloc", fa.o_ccu_addr, 32'h0000_6020);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      al = ($urandom % 2) == 0;
      if (($urandom % 10) == 0) ad = 32'hFFFF_FFE0 + ($urandom % 32);
      else ad = 32'h0000_7000 + ($urandom % 6) * 32 + ($urandom % 32);
      fl = ($urandom % 16) == 0;
      da = (msize[0] != 0) && (($urandom % 3) == 0);
      db = (msize[1] != 0) && (($urandom % 3) == 0);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(al, ad, fl, da, db, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
